// File: rtl/stream_pkg.sv
// Shared types and constants for the packed RGB888 stream receive path.
package stream_pkg;

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int PIX_PER_GROUP   = 4;
    localparam int WORDS_PER_GROUP = 3;

    // Counter width for a dimension of n positions, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_unpacker_raster_counter.sv
// Raster position tracker: holds the expected position of the next pixel,
// reports where the pixel being emitted lands, and counts completed frames.
module raster_counter
    import stream_pkg::*;
#(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        adv,
    input  logic                        force_origin,
    input  logic                        line_break,
    output logic [cnt_w(X_SIZE)-1:0]    exp_x,
    output logic [cnt_w(Y_SIZE)-1:0]    exp_y,
    output logic [cnt_w(X_SIZE)-1:0]    pos_x,
    output logic [cnt_w(Y_SIZE)-1:0]    pos_y,
    output logic                        pos_sof,
    output logic                        pos_eol,
    output logic [15:0]                 frame_cnt
);

    localparam int XW = cnt_w(X_SIZE);
    localparam int YW = cnt_w(Y_SIZE);
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic [XW-1:0] nxt_x;
    logic [YW-1:0] nxt_y;
    logic          wrap_frame;

    always_comb begin
        pos_x      = force_origin ? '0 : exp_x;
        pos_y      = force_origin ? '0 : exp_y;
        pos_sof    = (pos_x == '0) && (pos_y == '0);
        pos_eol    = (pos_x == X_LAST);
        nxt_x      = pos_x + 1'b1;
        nxt_y      = pos_y;
        wrap_frame = 1'b0;
        // An early line break behaves exactly like a natural line end.
        if (line_break || pos_eol) begin
            nxt_x = '0;
            if (pos_y == Y_LAST) begin
                nxt_y      = '0;
                wrap_frame = 1'b1;
            end else begin
                nxt_y = pos_y + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_x     <= '0;
            exp_y     <= '0;
            frame_cnt <= '0;
        end else if (adv) begin
            exp_x <= nxt_x;
            exp_y <= nxt_y;
            if (wrap_frame) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/stream_unpacker.sv
// Unpacks 3 AXI-Stream words into 4 RGB888 pixels with SOF/EOL framing checks.
// Optional per-frame colour sum enabled by defining STREAM_UNPACK_FRAME_SUM_EN.
//
// state | meaning
// PH0   | expect w0: emit p0, keep p1 low byte
// PH1   | expect w1: emit p1, keep p2 low two bytes
// PH2   | expect w2: emit p2, latch p3
// PH3   | no word taken: emit latched p3
module stream_unpacker
    import stream_pkg::*;
#(
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int ERR_CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 in_stream_tdata,
    input  logic [3:0]                  in_stream_tkeep,
    input  logic                        in_stream_tlast,
    input  logic                        in_stream_tuser,
    input  logic                        in_stream_tvalid,
    output logic                        in_stream_tready,
    output logic [7:0]                  pix_r,
    output logic [7:0]                  pix_g,
    output logic [7:0]                  pix_b,
    output logic [cnt_w(X_SIZE)-1:0]    pix_x,
    output logic [cnt_w(Y_SIZE)-1:0]    pix_y,
    output logic                        pix_sof,
    output logic                        pix_eol,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic [ERR_CNT_W-1:0]        sof_err_cnt,
    output logic [ERR_CNT_W-1:0]        eol_err_cnt,
`ifdef STREAM_UNPACK_FRAME_SUM_EN
    output logic [31:0]                 frame_sum,
    output logic                        frame_sum_valid,
`endif
    output logic [15:0]                 frame_cnt
);

    localparam int XW = cnt_w(X_SIZE);
    localparam int YW = cnt_w(Y_SIZE);
    localparam logic [XW-1:0] X_PEN = XW'(X_SIZE - 2);

    if (X_SIZE % PIX_PER_GROUP != 0) begin : g_bad_x_size
        $error("stream_unpacker: X_SIZE must be a multiple of 4");
    end

    phase_e        phase, phase_nxt, eff_phase;
    logic          rdy_en;
    logic [15:0]   residue;
    logic [23:0]   p3_hold;
    rgb_t          dec_pix;
    logic          out_ready, accept, emit_p3, adv;
    logic          exp_origin, sof_resync, sof_missing;
    logic          line_done, eol_early, eol_missing;
    logic [XW-1:0] exp_x, pos_x;
    logic [YW-1:0] exp_y, pos_y;
    logic          pos_sof, pos_eol;
    logic          unused_tkeep;

    assign unused_tkeep     = ^in_stream_tkeep;
    assign out_ready        = !pix_valid || pix_ready;
    // rdy_en keeps tready low until the first cycle after reset is released.
    assign in_stream_tready = rdy_en && !reset && (phase != PH3) && out_ready;
    assign accept           = in_stream_tvalid && in_stream_tready;
    assign emit_p3          = (phase == PH3) && out_ready;
    assign adv              = accept || emit_p3;

    raster_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_raster (
        .clk          (clk),
        .reset        (reset),
        .adv          (adv),
        .force_origin (sof_resync),
        .line_break   (eol_early),
        .exp_x        (exp_x),
        .exp_y        (exp_y),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .pos_sof      (pos_sof),
        .pos_eol      (pos_eol),
        .frame_cnt    (frame_cnt)
    );

    always_comb begin
        exp_origin  = (exp_x == '0) && (exp_y == '0);
        sof_resync  = 1'b0;
        sof_missing = 1'b0;
        eff_phase   = phase;
        if (accept) begin
            if (in_stream_tuser && ((phase != PH0) || !exp_origin)) begin
                sof_resync = 1'b1;
                eff_phase  = PH0;
            end else if (!in_stream_tuser && (phase == PH0) && exp_origin) begin
                sof_missing = 1'b1;
            end
        end
        line_done   = accept && (eff_phase == PH2) && (exp_x == X_PEN);
        eol_early   = accept && in_stream_tlast && !line_done;
        eol_missing = line_done && !in_stream_tlast;

        case (eff_phase)
            PH0:     dec_pix = in_stream_tdata[23:0];
            PH1:     dec_pix = {in_stream_tdata[15:0], residue[7:0]};
            PH2:     dec_pix = {in_stream_tdata[7:0], residue};
            default: dec_pix = p3_hold;
        endcase

        phase_nxt = phase;
        if (accept) begin
            if (eol_early) begin
                phase_nxt = PH0;
            end else begin
                case (eff_phase)
                    PH0:     phase_nxt = PH1;
                    PH1:     phase_nxt = PH2;
                    default: phase_nxt = PH3;
                endcase
            end
        end else if (emit_p3) begin
            phase_nxt = PH0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH0;
        end else begin
            phase <= phase_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_en      <= 1'b0;
            residue     <= '0;
            p3_hold     <= '0;
            pix_valid   <= 1'b0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            sof_err_cnt <= '0;
            eol_err_cnt <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                case (eff_phase)
                    PH0:     residue <= {8'h00, in_stream_tdata[31:24]};
                    PH1:     residue <= in_stream_tdata[31:16];
                    PH2:     p3_hold <= in_stream_tdata[31:8];
                    default: ;
                endcase
            end
            if (adv) begin
                pix_valid <= 1'b1;
                pix_r     <= dec_pix.r;
                pix_g     <= dec_pix.g;
                pix_b     <= dec_pix.b;
                pix_x     <= pos_x;
                pix_y     <= pos_y;
                pix_sof   <= pos_sof;
                pix_eol   <= pos_eol;
            end else if (out_ready) begin
                pix_valid <= 1'b0;
            end
            if ((sof_resync || sof_missing) && (sof_err_cnt != '1)) begin
                sof_err_cnt <= sof_err_cnt + 1'b1;
            end
            if ((eol_early || eol_missing) && (eol_err_cnt != '1)) begin
                eol_err_cnt <= eol_err_cnt + 1'b1;
            end
        end
    end

`ifdef STREAM_UNPACK_FRAME_SUM_EN
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic [31:0] sum_acc, sum_total;
    logic        pix_hs, pix_last;

    assign pix_hs    = pix_valid && pix_ready;
    assign pix_last  = (pix_x == X_LAST) && (pix_y == Y_LAST);
    // Any origin pixel, natural or resynced, starts a fresh sum.
    assign sum_total = (pix_sof ? 32'd0 : sum_acc)
                     + 32'(pix_r) + 32'(pix_g) + 32'(pix_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_acc         <= '0;
            frame_sum       <= '0;
            frame_sum_valid <= 1'b0;
        end else begin
            frame_sum_valid <= 1'b0;
            if (pix_hs) begin
                if (pix_last) begin
                    frame_sum       <= sum_total;
                    frame_sum_valid <= 1'b1;
                    sum_acc         <= '0;
                end else begin
                    sum_acc <= sum_total;
                end
            end
        end
    end
`endif

endmodule

// File: doc/stream_unpacker.md
Name: stream_unpacker

Overview:
- Receive end of the 32-bit AXI-Stream video link driven by the pixel packer.
- Unpacks 3 words into 4 RGB888 pixels and tracks the x/y raster position.
- Checks SOF (tuser) and EOL (tlast) framing and presents one pixel per handshake to a downstream consumer.
- Sits in loopback/verification paths and frame-capture logic beside the Mandelbrot pixel generator.

Parameters:
- X_SIZE, 640: pixels per line; must be a multiple of 4 (elaboration error otherwise).
- Y_SIZE, 480: lines per frame.
- ERR_CNT_W, 8: width of the saturating error counters.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- in_stream_tdata  in  32  packed pixel bytes.
- in_stream_tkeep  in  4  ignored; all words are full.
- in_stream_tlast  in  1  last word of a line.
- in_stream_tuser  in  1  first word of a frame.
- in_stream_tvalid  in  1  word valid.
- in_stream_tready  out  1  word accepted when tvalid & tready.
- pix_r, pix_g, pix_b  out  8 each  pixel colour.
- pix_x  out  $clog2(X_SIZE)  column of the presented pixel.
- pix_y  out  $clog2(Y_SIZE)  row of the presented pixel.
- pix_sof  out  1  pixel is (0,0).
- pix_eol  out  1  pixel is x == X_SIZE-1.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  consumer accepts pixel.
- sof_err_cnt  out  ERR_CNT_W  saturating count of SOF framing errors.
- eol_err_cnt  out  ERR_CNT_W  saturating count of EOL framing errors.
- frame_cnt  out  16  completed frames; wraps.

Behaviour:
- Packing format:
  - pixel p = {r,g,b}, with b in bits 7:0.
  - w0 = {p1[7:0], p0[23:0]}
  - w1 = {p2[15:0], p1[23:8]}
  - w2 = {p3[23:0], p2[23:16]}
- Phase FSM:
  - PH0: accept w0, emit p0, hold 1 residue byte.
  - PH1: accept w1, emit p1, hold 2 residue bytes.
  - PH2: accept w2, emit p2, latch p3.
  - PH3: emit p3 with no word consumed.
  - Transitions: PH0→PH1→PH2→PH3→PH0.
- Output register is single-entry.
- in_stream_tready = (phase != PH3) & (!pix_valid | pix_ready).
- Latency: an accepted word's pixel appears on pix_* the next cycle.
- Sustained rate is 4 pixels per 4 cycles (3 words).
- pix_* are stable while pix_valid & !pix_ready. pix_valid never drops without a handshake.
- Position counters:
  - x increments on each emitted pixel.
  - At X_SIZE-1, x wraps to 0 and y increments.
  - At (X_SIZE-1, Y_SIZE-1) both wrap and frame_cnt increments.
- tuser at PH0 with expected position ≠ (0,0): sof_err_cnt += 1. Force x=y=0; the emitted pixel has pix_sof=1.
- tuser at PH1/PH2: sof_err_cnt += 1. Discard the residue and treat the word as w0 of a new frame (PH0 decode, x=y=0).
- Expected position (0,0) at PH0 but tuser=0: sof_err_cnt += 1. Continue unchanged; pix_sof is still asserted from position.
- tlast on a word that does not complete the line: eol_err_cnt += 1. Discard the residue, go to PH0, set x=0, advance y as at a normal line end.
- Line-completing word (w2 whose p3 is at x = X_SIZE-1) without tlast: eol_err_cnt += 1. The line wraps normally.
- tuser and tlast on the same word: the SOF rule applies first, then the EOL rule.
- Error counters saturate at all-ones.
- Reset (any cycle, including mid-frame or with a pixel pending):
  - pix_valid=0, tready=0 during reset.
  - phase=PH0; x=y=0; residue cleared.
  - pix_r/g/b=0, pix_sof=pix_eol=0.
  - All counters 0; a pending pixel is dropped.
- tready rises the cycle after reset deasserts.

Optional Feature:
- Macro: STREAM_UNPACK_FRAME_SUM_EN.
- When defined, adds output frame_sum (32 bits) and output frame_sum_valid (1 bit).
  - frame_sum accumulates r+g+b of every handshaked pixel, wrapping modulo 2^32.
  - At the handshake of the last pixel of a frame, frame_sum presents the total including that pixel, and frame_sum_valid pulses for 1 cycle.
  - The accumulator clears on that cycle and on SOF resync.
  - Both outputs are 0 on reset.
- When undefined, the ports and logic are absent and nothing else changes.

Decomposition:
- Package stream_pkg:
  - phase enum (PH0..PH3).
  - rgb_t struct {r,g,b}.
  - PIX_PER_GROUP=4, WORDS_PER_GROUP=3.
  - Localparam helpers for X/Y counter widths.
- One sub-module, raster_counter: x/y/frame counting with wrap, sof/eol flags, and a force-to-origin input.

Test Plan:
- One frame of X_SIZE=8, Y_SIZE=2, pixel p=i (i=0..15, as {r,g,b}), with correct tuser/tlast and pix_ready=1 → 16 pixels in order; pix_sof only on pixel 0; pix_eol on x=7; frame_cnt=1; both error counts 0.
- Same stream with pix_ready toggling 1010… and random tvalid gaps → identical pixel sequence; no pixel changes while stalled; tready low in PH3 and while stalled.
- tuser on the 2nd word of the frame (w1 position) → sof_err_cnt=1; residue dropped; that word decoded as w0 with pix_sof=1 at (0,0).
- tlast on word 4 of an 8-pixel line (w0 of group 2) → eol_err_cnt=1; next word decoded as w0 at x=0, y=1.
- Reset asserted while PH3 holds a pending p3 → pix_valid=0 and all counters 0 next cycle; the following frame decodes cleanly.
- With STREAM_UNPACK_FRAME_SUM_EN, a 16-pixel frame of all {1,2,3} → frame_sum=96 with a single-cycle frame_sum_valid pulse.
